// File: rtl/cmp_arb_pkg.sv
// cmp_arb shared types: FSM state, default sizes, result bundle.
// Build option CMP_ARB_SIGNED_EN selects two's-complement compare.
package cmp_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int WIDTH_DEF = 16;
    localparam int ID_W = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            eq;
        logic            lt;
        logic            gt;
    } result_t;

endpackage

// File: rtl/cmp_arb_cmp_mag.sv
// cmp_mag: combinational WIDTH-bit magnitude comparator.
// CMP_ARB_SIGNED_EN defined -> signed compare, else unsigned.
module cmp_mag #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    assign eq = (a == b);
`ifdef CMP_ARB_SIGNED_EN
    assign lt = ($signed(a) < $signed(b));
`else
    assign lt = (a < b);
`endif
    assign gt = ~eq & ~lt;

endmodule

// File: rtl/cmp_arb.sv
// cmp_arb: round-robin arbiter feeding one shared comparator.
// Build option CMP_ARB_SIGNED_EN selects two's-complement compare.
module cmp_arb
    import cmp_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0] req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] req_b,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic                       rsp_eq,
    output logic                       rsp_lt,
    output logic                       rsp_gt,
    output logic [15:0]                cmp_count
);

    localparam int IDW = $clog2(NREQ);

    state_t          state_q;
    state_t          state_d;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  hi_idx;
    logic [IDW-1:0]  lo_idx;
    logic [NREQ-1:0] req_hi;
    logic            grant_ok;
    logic            grant;
    logic            rsp_fire;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic            c_eq;
    logic            c_lt;
    logic            c_gt;
    result_t         res_q;
    result_t         res_d;
    logic [15:0]     cnt_q;
    logic            unused_id;

    // Requests at/after rr_ptr win; otherwise wrap to lowest index.
    always_comb begin
        req_hi = '0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            req_hi[i] = req_valid[i] && (i >= int'(rr_ptr));
            if (req_valid[i]) lo_idx = IDW'(i);
            if (req_hi[i]) hi_idx = IDW'(i);
        end
        gnt_idx = (|req_hi) ? hi_idx : lo_idx;
    end

    assign grant_ok = ~rst & ((state_q == ST_EMPTY) | rsp_ready);
    assign grant    = grant_ok & (|req_valid);
    assign rsp_fire = (state_q == ST_FULL) & rsp_ready;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[gnt_idx] = 1'b1;
    end

    assign sel_a = req_a[gnt_idx];
    assign sel_b = req_b[gnt_idx];

    cmp_mag #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a  (sel_a),
        .b  (sel_b),
        .eq (c_eq),
        .lt (c_lt),
        .gt (c_gt)
    );

    always_comb begin
        res_d    = res_q;
        res_d.id = ID_W'(gnt_idx);
        res_d.eq = c_eq;
        res_d.lt = c_lt;
        res_d.gt = c_gt;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (grant) state_d = ST_FULL;
            ST_FULL:  if (rsp_ready && !grant) state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            rr_ptr  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0
                        : gnt_idx + 1'b1;
                res_q  <= res_d;
            end
            if (rsp_fire) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = res_q.id[IDW-1:0];
    assign rsp_eq    = res_q.eq;
    assign rsp_lt    = res_q.lt;
    assign rsp_gt    = res_q.gt;
    assign cmp_count = cnt_q;
    assign unused_id = ^res_q.id;

endmodule

// File: doc/cmp_arb.md
CMP_ARB -- requirements
Module: cmp_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit wide, and is the reset: synchronous and active-high.
REQ-005 Port req_valid SHALL be an input, NREQ bits wide, with one request-valid bit per requester.
REQ-006 Port req_a SHALL be an input, NREQ x WIDTH bits wide, carrying operand A per requester.
REQ-007 Port req_b SHALL be an input, NREQ x WIDTH bits wide, carrying operand B per requester.
REQ-008 Port req_ready SHALL be an output, NREQ bits wide, and is one-hot or zero: the grant/accept per requester.
REQ-009 Port rsp_valid SHALL be an output, 1 bit wide, indicating the result register is occupied.
REQ-010 Port rsp_ready SHALL be an input, 1 bit wide, and is the downstream accept.
REQ-011 Port rsp_id SHALL be an output, clog2(NREQ) bits wide, giving the index of the requester that owns the result.
REQ-012 Ports rsp_eq, rsp_lt and rsp_gt SHALL be outputs, 1 bit each: A==B, A<B and A>B for the owning request.
REQ-013 Port cmp_count SHALL be an output, 16 bits wide, counting completed comparisons (responses accepted downstream).

Function
REQ-014 A single shared combinational WIDTH-bit magnitude comparator SHALL serve all requesters; exactly one request is compared per cycle at most.
REQ-015 Handshake: a request transfers when req_valid[i] & req_ready[i]; a response transfers when rsp_valid & rsp_ready.
REQ-016 The output register FSM SHALL have two states. In EMPTY, a grant loads the register and moves the FSM to FULL. In FULL with rsp_ready high, the FSM returns to EMPTY, or stays FULL if a new grant occurs in the same cycle. In FULL with rsp_ready low, the FSM stays FULL and grants nothing.
REQ-017 Grant is allowed only when the FSM is EMPTY or (FULL & rsp_ready), giving full throughput of one result per cycle under continuous demand.
REQ-018 Arbitration SHALL be round-robin: the grant goes to the lowest index at or after pointer rr_ptr, wrapping modulo NREQ.
REQ-019 After a grant to index g, rr_ptr SHALL become (g+1) mod NREQ; rr_ptr SHALL be unchanged when no grant occurs.
REQ-020 req_ready SHALL be combinationally derived from req_valid, rr_ptr and grant-allowed, and SHALL never assert for a requester whose req_valid is low.
REQ-021 Latency: rsp_valid SHALL assert the cycle after acceptance, with rsp_id, rsp_eq, rsp_lt and rsp_gt registered from the accepted operands.
REQ-022 While rsp_valid is high, exactly one of rsp_eq, rsp_lt and rsp_gt SHALL be high.
REQ-023 The response fields SHALL hold stable while rsp_valid & ~rsp_ready.
REQ-024 The response fields SHALL retain their last values when the FSM is EMPTY.
REQ-025 cmp_count SHALL increment on each response transfer and wrap from 16'hFFFF to 0.
REQ-026 Operand changes on a non-granted requester SHALL have no effect on any output.

Reset
REQ-027 While rst is high at a clock edge, the FSM SHALL go to EMPTY, rr_ptr to 0, cmp_count to 0, and rsp_id, rsp_eq, rsp_lt and rsp_gt to 0.
REQ-028 req_ready SHALL be all-zero during any cycle in which rst is high.
REQ-029 A reset asserted mid-operation SHALL discard any pending response without a transfer and without a count.

Configuration
REQ-030 Macro CMP_ARB_SIGNED_EN SHALL select the comparison mode: when defined, the comparator treats A and B as two's-complement; when undefined, it treats them as unsigned.
REQ-031 The macro SHALL affect only the comparator; handshake, arbitration and timing SHALL be identical in both builds.

Structure
REQ-032 Package cmp_arb_pkg SHALL hold the FSM state enum (ST_EMPTY, ST_FULL), the default constants NREQ_DEF=4 and WIDTH_DEF=16, and the result struct {id, eq, lt, gt}.
REQ-033 The comparator SHALL be a sub-module cmp_mag (a purely combinational WIDTH-bit compare producing eq, lt and gt, and honouring CMP_ARB_SIGNED_EN); arbitration, FSM and counter SHALL live in cmp_arb.

Verification
REQ-034 Single request: req_valid=4'b0100, A=16'h1234, B=16'h1234, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=2, eq=1, rr_ptr=3, cmp_count=1 after the transfer.
REQ-035 All four requesters valid continuously, rsp_ready=1, rr_ptr=0 -> grants in order 0,1,2,3,0 on consecutive cycles, one response per cycle.
REQ-036 Backpressure: with the FSM FULL and rsp_ready=0 for 3 cycles -> req_ready=0 and response fields stable; with rsp_ready=1 -> the transfer occurs and a new grant happens in the same cycle.
REQ-037 Signedness: A=16'h8000, B=16'h0001 -> lt=1 with CMP_ARB_SIGNED_EN defined; gt=1 without it.
REQ-038 Reset mid-operation: rst asserted while FULL -> next cycle rsp_valid=0, rr_ptr=0, cmp_count=0; no transfer is counted.
REQ-039 Counter wrap: preload via 65535 transfers, then one more transfer -> cmp_count=0.
